// File: rtl/p.sv
// Shared ROB definitions for dispatch, rob_ctrl and retire/rename.
package p;

    localparam int ROB_DEPTH = 16;

    localparam logic [1:0] INSTR_REG = 2'd0;
    localparam logic [1:0] INSTR_SW  = 2'd1;
    localparam logic [1:0] INSTR_LW  = 2'd2;

    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_LW = 7'b0000011;

    typedef struct packed {
        logic        v;
        logic        comp;
        logic [1:0]  typ;
        logic [6:0]  pc;
        logic [5:0]  phy;
        logic [5:0]  old_phy;
        logic [31:0] result;
    } rob_row;

    function automatic logic [1:0] instr_type(
        input logic [6:0] op
    );
        logic [1:0] t;
        unique case (1'b1)
            op == OP_SW: t = INSTR_SW;
            op == OP_LW: t = INSTR_LW;
            default:     t = INSTR_REG;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: dual in-order allocate, three
// completion ports, dual in-order retire with a done counter.
module rob_ctrl
    import p::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              tot_instr_count,
    input  logic                     alloc_valid_1,
    input  logic                     alloc_valid_2,
    input  logic [6:0]               alloc_op_1,
    input  logic [6:0]               alloc_op_2,
    input  logic [6:0]               alloc_pc_1,
    input  logic [6:0]               alloc_pc_2,
    input  logic [5:0]               alloc_phy_1,
    input  logic [5:0]               alloc_phy_2,
    input  logic [5:0]               alloc_old_phy_1,
    input  logic [5:0]               alloc_old_phy_2,
    output logic                     alloc_ready,
    output logic [$clog2(DEPTH)-1:0] alloc_tag_1,
    output logic [$clog2(DEPTH)-1:0] alloc_tag_2,
    input  logic                     cmp_valid_1,
    input  logic                     cmp_valid_2,
    input  logic                     cmp_valid_3,
    input  logic [$clog2(DEPTH)-1:0] cmp_tag_1,
    input  logic [$clog2(DEPTH)-1:0] cmp_tag_2,
    input  logic [$clog2(DEPTH)-1:0] cmp_tag_3,
    input  logic [31:0]              cmp_result_1,
    input  logic [31:0]              cmp_result_2,
    input  logic [31:0]              cmp_result_3,
    output logic                     rt_flag_1,
    output logic                     rt_flag_2,
    output logic [1:0]               rt_type_1,
    output logic [1:0]               rt_type_2,
    output logic [5:0]               rt_phy_1,
    output logic [5:0]               rt_phy_2,
    output logic [5:0]               fp_i_1,
    output logic [5:0]               fp_i_2,
    output logic [31:0]              rt_result_1,
    output logic [31:0]              rt_result_2,
    output logic                     empty,
    output logic                     full,
    output logic                     err,
    output logic                     done
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = TW + 1;

    rob_row          rob [DEPTH];
    logic [TW-1:0]   head;
    logic [TW-1:0]   tail;
    logic [TW-1:0]   head_p1;
    logic [TW-1:0]   tail_p1;
    logic [CW-1:0]   count;
    logic [31:0]     retired;
    logic [31:0]     retired_next;

    logic            acc1;
    logic            acc2;
    logic            ret1;
    logic            ret2;
    logic [1:0]      n_acc;
    logic [1:0]      n_ret;
    rob_row          row1;
    rob_row          row2;

    logic [2:0]      cv;
    logic [TW-1:0]   ct [3];
    logic [31:0]     cr [3];
    logic [DEPTH-1:0] wr_hit;
    logic [31:0]     wr_val [DEPTH];
    logic            cmp_err;

    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    assign alloc_ready = count <= CW'(DEPTH - 2);
    assign alloc_tag_1 = tail;
    assign alloc_tag_2 = tail_p1;
    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);

    assign acc1  = alloc_valid_1 && alloc_ready;
    assign acc2  = acc1 && alloc_valid_2;
    assign n_acc = {1'b0, acc1} + {1'b0, acc2};

    // Retire decisions see only completions from earlier edges.
    assign ret1  = !done && rob[head].v && rob[head].comp;
    assign ret2  = ret1 && rob[head_p1].v && rob[head_p1].comp;
    assign n_ret = {1'b0, ret1} + {1'b0, ret2};

    assign retired_next = retired + 32'(n_ret);

    always_comb begin
        row1         = '0;
        row1.v       = 1'b1;
        row1.typ     = instr_type(alloc_op_1);
        row1.pc      = alloc_pc_1;
        row1.phy     = alloc_phy_1;
        row1.old_phy = alloc_old_phy_1;
        row2         = '0;
        row2.v       = 1'b1;
        row2.typ     = instr_type(alloc_op_2);
        row2.pc      = alloc_pc_2;
        row2.phy     = alloc_phy_2;
        row2.old_phy = alloc_old_phy_2;
    end

    assign cv    = {cmp_valid_3, cmp_valid_2, cmp_valid_1};
    assign ct[0] = cmp_tag_1;
    assign ct[1] = cmp_tag_2;
    assign ct[2] = cmp_tag_3;
    assign cr[0] = cmp_result_1;
    assign cr[1] = cmp_result_2;
    assign cr[2] = cmp_result_3;

    // Lowest port claims a tag first; later hits on it are errors.
    always_comb begin
        wr_hit  = '0;
        cmp_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_val[i] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            if (cv[k]) begin
                if (!rob[ct[k]].v || wr_hit[ct[k]]) begin
                    cmp_err = 1'b1;
                end else begin
                    wr_hit[ct[k]] = 1'b1;
                    wr_val[ct[k]] = cr[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            retired <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    rob[i].comp   <= 1'b1;
                    rob[i].result <= wr_val[i];
                end
            end
            if (acc1) begin
                rob[tail] <= row1;
            end
            if (acc2) begin
                rob[tail_p1] <= row2;
            end
            if (ret1) begin
                rob[head].v    <= 1'b0;
                rob[head].comp <= 1'b0;
            end
            if (ret2) begin
                rob[head_p1].v    <= 1'b0;
                rob[head_p1].comp <= 1'b0;
            end
            head    <= head + TW'(n_ret);
            tail    <= tail + TW'(n_acc);
            count   <= count + CW'(n_acc) - CW'(n_ret);
            retired <= retired_next;
            err     <= err | cmp_err;
            if (tot_instr_count != '0 &&
                retired_next == tot_instr_count) begin
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rt_flag_1   <= 1'b0;
            rt_flag_2   <= 1'b0;
            rt_type_1   <= '0;
            rt_type_2   <= '0;
            rt_phy_1    <= '0;
            rt_phy_2    <= '0;
            fp_i_1      <= '0;
            fp_i_2      <= '0;
            rt_result_1 <= '0;
            rt_result_2 <= '0;
        end else begin
            rt_flag_1 <= ret1;
            rt_flag_2 <= ret2;
            if (ret1) begin
                rt_type_1   <= rob[head].typ;
                rt_phy_1    <= rob[head].phy;
                fp_i_1      <= rob[head].old_phy;
                rt_result_1 <= rob[head].result;
            end
            if (ret2) begin
                rt_type_2   <= rob[head_p1].typ;
                rt_phy_2    <= rob[head_p1].phy;
                fp_i_2      <= rob[head_p1].old_phy;
                rt_result_2 <= rob[head_p1].result;
            end
        end
    end

endmodule
